// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory controller.
//   - Line geometry (log2 line size, line size in bytes and bits).
//   - FSM state and operation-kind enums.
//   - IO access-type encodings and a helper that turns one into a byte count.
package mem_ctrl_pkg;

    localparam int unsigned BLOCK_WIDTH = 4;
    localparam int unsigned BLOCK_SIZE  = 2 ** BLOCK_WIDTH;
    localparam int unsigned LINE_BITS   = BLOCK_SIZE * 8;

    localparam logic [1:0] ACC_BYTE = 2'b01;
    localparam logic [1:0] ACC_HALF = 2'b10;
    localparam logic [1:0] ACC_WORD = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StWb,
        StIoRd,
        StIoWr,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        OpFill,
        OpWb,
        OpIoRd,
        OpIoWr
    } op_e;

    // The unused 2'b00 encoding is treated as a single byte.
    function automatic logic [4:0] access_bytes(input logic [1:0] acc_type);
        logic [4:0] n;
        case (acc_type)
            ACC_HALF: n = 5'd2;
            ACC_WORD: n = 5'd4;
            default:  n = 5'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/line_shift_reg.sv
// line_shift_reg: one cache line of storage shared by every transfer type.
//   clk_i, rst_i      clock, asynchronous active-high reset (clears the line)
//   load_i            parallel load of load_data_i (wins over shift_i)
//   load_data_i       line to load
//   shift_i           shift right by one byte, shift_byte_i entering at the top
//   shift_byte_i      byte inserted at the top on a shift
//   line_o            parallel read of the whole line
//   byte_o            lowest byte, i.e. the next byte to shift out
// Shifting in N bytes leaves the first one received at byte (Bytes - N), so
// a full-line fill ends with byte 0 in [7:0].
module line_shift_reg #(
    parameter int unsigned Bytes = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [Bytes*8-1:0]   load_data_i,
    input  logic                 shift_i,
    input  logic [7:0]           shift_byte_i,
    output logic [Bytes*8-1:0]   line_o,
    output logic [7:0]           byte_o
);

    logic [Bytes*8-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_data_i;
        end else if (shift_i) begin
            line_d = {shift_byte_i, line_q[Bytes*8-1:8]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;
    assign byte_o = line_q[7:0];

endmodule

// File: rtl/mem_controller.sv
// mem_controller: byte-wide RAM responder for cache line fills, dirty-line
// write-backs and 1/2/4-byte uncached IO accesses, one request at a time.
//   Cache side : missIn/missAddrIn/readWriteIn/writeBackIn in;
//                memDataValid/memAddr/memDataOut/acceptWrite out (1-cycle pulses).
//   IO side    : mutableReq/mutableRW/mutableType/mutableAddr/mutableData in;
//                mutableMemInValid/mutableMemDataOut/mutableWriteSuc out.
//   RAM side   : ramAddr/ramWrite/ramDataOut out, ramDataIn in (1-cycle latency).
//   Control    : readyIn freezes everything, clearIn blocks IO read acceptance,
//                ioBufferFull stalls IO writes when MEM_CTRL_IO_FULL_CHECK_EN
//                is defined (ignored otherwise).
module mem_controller
    import mem_ctrl_pkg::*;
(
    input  logic                    clkIn,
    input  logic                    resetIn,
    input  logic                    readyIn,
    input  logic                    clearIn,
    input  logic                    missIn,
    input  logic [31:BLOCK_WIDTH]   missAddrIn,
    input  logic                    readWriteIn,
    input  logic [LINE_BITS-1:0]    writeBackIn,
    output logic                    memDataValid,
    output logic [31:BLOCK_WIDTH]   memAddr,
    output logic [LINE_BITS-1:0]    memDataOut,
    output logic                    acceptWrite,
    input  logic                    mutableReq,
    input  logic                    mutableRW,
    input  logic [1:0]              mutableType,
    input  logic [31:0]             mutableAddr,
    input  logic [31:0]             mutableData,
    output logic                    mutableMemInValid,
    output logic [31:0]             mutableMemDataOut,
    output logic                    mutableWriteSuc,
    input  logic [7:0]              ramDataIn,
    output logic [7:0]              ramDataOut,
    output logic [31:0]             ramAddr,
    output logic                    ramWrite,
    input  logic                    ioBufferFull
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  nbytes_q, nbytes_d;
    logic [31:0] base_q, base_d;
    logic        prime_q, prime_d;  // ramDataIn this cycle is stale after a rewind
    logic        rdy_q;             // readyIn of the previous cycle

    logic                 line_load, line_shift;
    logic [LINE_BITS-1:0] line_load_data, line;
    logic [7:0]           line_shift_byte, line_byte;

    logic        rd_state, wr_state, io_stall;
    logic [4:0]  rd_idx;
    logic [31:0] io_word;
    logic        done_fill, done_wb, done_iord, done_iowr;

    assign rd_state = (state_q == StFill) || (state_q == StIoRd);
    assign wr_state = (state_q == StWb) || (state_q == StIoWr);

`ifdef MEM_CTRL_IO_FULL_CHECK_EN
    assign io_stall = (state_q == StIoWr) && ioBufferFull;
`else
    logic unused_io_full;
    assign unused_io_full = ioBufferFull;
    assign io_stall = 1'b0;
`endif

    // Reads are pipelined: the counter is the index being addressed and the
    // byte for index cnt-1 is captured. After the last byte is addressed the
    // address holds so no extra location (possibly a side-effecting IO
    // register) is read.
    assign rd_idx = (cnt_q >= nbytes_q) ? nbytes_q - 5'd1 : cnt_q;

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        cnt_d           = cnt_q;
        nbytes_d        = nbytes_q;
        base_d          = base_q;
        prime_d         = prime_q;
        line_load       = 1'b0;
        line_load_data  = writeBackIn;
        line_shift      = 1'b0;
        line_shift_byte = 8'h00;
        if (readyIn) begin
            unique case (state_q)
                StIdle: begin
                    cnt_d   = 5'd0;
                    prime_d = 1'b0;
                    if (missIn) begin
                        base_d   = {missAddrIn, {BLOCK_WIDTH{1'b0}}};
                        nbytes_d = 5'(BLOCK_SIZE);
                        if (readWriteIn) begin
                            state_d = StFill;
                            op_d    = OpFill;
                        end else begin
                            state_d   = StWb;
                            op_d      = OpWb;
                            line_load = 1'b1;
                        end
                    end else if (mutableReq && !(mutableRW && clearIn)) begin
                        base_d   = mutableAddr;
                        nbytes_d = access_bytes(mutableType);
                        if (mutableRW) begin
                            state_d = StIoRd;
                            op_d    = OpIoRd;
                        end else begin
                            state_d        = StIoWr;
                            op_d           = OpIoWr;
                            line_load      = 1'b1;
                            line_load_data = {{(LINE_BITS-32){1'b0}}, mutableData};
                        end
                    end
                end
                StFill, StIoRd: begin
                    if ((cnt_q == 5'd0) || prime_q) begin
                        // Nothing valid to capture yet; just issue the next address.
                        cnt_d   = cnt_q + 5'd1;
                        prime_d = 1'b0;
                    end else if (!rdy_q) begin
                        // First cycle after a freeze: the byte for cnt-1 returned
                        // while frozen and was lost, so re-address it.
                        cnt_d   = cnt_q - 5'd1;
                        prime_d = 1'b1;
                    end else begin
                        line_shift      = 1'b1;
                        line_shift_byte = ramDataIn;
                        if (cnt_q == nbytes_q) begin
                            state_d = StDone;
                            cnt_d   = 5'd0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                StWb, StIoWr: begin
                    if (!io_stall) begin
                        line_shift = 1'b1;
                        if (cnt_q == nbytes_q - 5'd1) begin
                            state_d = StDone;
                            cnt_d   = 5'd0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state_q  <= StIdle;
            op_q     <= OpFill;
            cnt_q    <= 5'd0;
            nbytes_q <= 5'd0;
            base_q   <= 32'd0;
            prime_q  <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            nbytes_q <= nbytes_d;
            base_q   <= base_d;
            prime_q  <= prime_d;
            rdy_q    <= readyIn;
        end
    end

    line_shift_reg #(
        .Bytes (BLOCK_SIZE)
    ) u_line (
        .clk_i        (clkIn),
        .rst_i        (resetIn),
        .load_i       (line_load),
        .load_data_i  (line_load_data),
        .shift_i      (line_shift),
        .shift_byte_i (line_shift_byte),
        .line_o       (line),
        .byte_o       (line_byte)
    );

    // IO read bytes sit at the top of the line, first byte lowest.
    always_comb begin
        case (nbytes_q)
            5'd1:    io_word = {24'd0, line[LINE_BITS-1 -: 8]};
            5'd2:    io_word = {16'd0, line[LINE_BITS-1 -: 16]};
            default: io_word = line[LINE_BITS-1 -: 32];
        endcase
    end

    assign done_fill = (state_q == StDone) && (op_q == OpFill);
    assign done_wb   = (state_q == StDone) && (op_q == OpWb);
    assign done_iord = (state_q == StDone) && (op_q == OpIoRd);
    assign done_iowr = (state_q == StDone) && (op_q == OpIoWr);

    assign ramWrite   = wr_state && readyIn && !io_stall;
    assign ramDataOut = wr_state ? line_byte : 8'h00;
    assign ramAddr    = rd_state ? base_q + {27'd0, rd_idx} :
                        wr_state ? base_q + {27'd0, cnt_q} : 32'd0;

    assign memDataValid      = done_fill;
    assign acceptWrite       = done_wb;
    assign memAddr           = (done_fill || done_wb) ? base_q[31:BLOCK_WIDTH] : '0;
    assign memDataOut        = done_fill ? line : '0;
    assign mutableMemInValid = done_iord;
    assign mutableMemDataOut = done_iord ? io_word : 32'd0;
    assign mutableWriteSuc   = done_iowr;

endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed bench for mem_controller. Inputs change 1 time
// unit after the rising edge; outputs are sampled 2 time units after it.
// Cycle numbers in the comments count from the cycle a request is first seen.
module tb_mem_controller;
    import mem_ctrl_pkg::*;

`ifdef MEM_CTRL_IO_FULL_CHECK_EN
    localparam int WrCyc  = 3;
    localparam int SucCyc = 4;
`else
    localparam int WrCyc  = 1;
    localparam int SucCyc = 2;
`endif

    logic                  clkIn = 1'b0;
    logic                  resetIn, readyIn, clearIn, missIn, readWriteIn;
    logic [31:BLOCK_WIDTH] missAddrIn;
    logic [LINE_BITS-1:0]  writeBackIn;
    logic                  memDataValid, acceptWrite;
    logic [31:BLOCK_WIDTH] memAddr;
    logic [LINE_BITS-1:0]  memDataOut;
    logic                  mutableReq, mutableRW;
    logic [1:0]            mutableType;
    logic [31:0]           mutableAddr, mutableData, mutableMemDataOut;
    logic                  mutableMemInValid, mutableWriteSuc;
    logic [7:0]            ramDataIn, ramDataOut;
    logic [31:0]           ramAddr;
    logic                  ramWrite, ioBufferFull;

    int    n_pass   = 0;
    int    n_checks = 0;
    logic  seen;
    logic [31:0] rd_word;

    always #5 clkIn = ~clkIn;

    mem_controller dut (
        .clkIn             (clkIn),
        .resetIn           (resetIn),
        .readyIn           (readyIn),
        .clearIn           (clearIn),
        .missIn            (missIn),
        .missAddrIn        (missAddrIn),
        .readWriteIn       (readWriteIn),
        .writeBackIn       (writeBackIn),
        .memDataValid      (memDataValid),
        .memAddr           (memAddr),
        .memDataOut        (memDataOut),
        .acceptWrite       (acceptWrite),
        .mutableReq        (mutableReq),
        .mutableRW         (mutableRW),
        .mutableType       (mutableType),
        .mutableAddr       (mutableAddr),
        .mutableData       (mutableData),
        .mutableMemInValid (mutableMemInValid),
        .mutableMemDataOut (mutableMemDataOut),
        .mutableWriteSuc   (mutableWriteSuc),
        .ramDataIn         (ramDataIn),
        .ramDataOut        (ramDataOut),
        .ramAddr           (ramAddr),
        .ramWrite          (ramWrite),
        .ioBufferFull      (ioBufferFull)
    );

    // RAM contents: line 0x1200 holds k+1 at byte k, 0x30000.. holds 0x41..0x44.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        if (a[31:4] == 28'h0000120) return {4'h0, a[3:0]} + 8'd1;
        if (a[31:2] == 30'h0000C000) return 8'h41 + {6'd0, a[1:0]};
        return 8'hEE;
    endfunction

    always @(posedge clkIn) ramDataIn <= ram_byte(ramAddr);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        resetIn      = 1'b1;
        readyIn      = 1'b1;
        clearIn      = 1'b0;
        missIn       = 1'b0;
        readWriteIn  = 1'b0;
        missAddrIn   = '0;
        writeBackIn  = '0;
        mutableReq   = 1'b0;
        mutableRW    = 1'b0;
        mutableType  = 2'b00;
        mutableAddr  = 32'd0;
        mutableData  = 32'd0;
        ioBufferFull = 1'b0;
        seen         = 1'b0;
        rd_word      = 32'd0;

        repeat (2) @(posedge clkIn);
        #2;
        check("reset_ramAddr", ramAddr, 0);
        check("reset_ramWrite", ramWrite, 0);
        check("reset_memDataValid", memDataValid, 0);
        check("reset_acceptWrite", acceptWrite, 0);
        check("reset_ioPulses", {mutableMemInValid, mutableWriteSuc}, 0);
        check("reset_memDataOut", memDataOut, 0);
        resetIn = 1'b0;
        tick();

        // Line fill of 0x00120, missIn held through DONE.
        missIn      = 1'b1;
        readWriteIn = 1'b1;
        missAddrIn  = 28'h0000120;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 19) missIn = 1'b0;
            #1;
            if (c <= 16) check("fill_addr", ramAddr, 32'h1200 + c - 1);
            check("fill_we", ramWrite, 0);
            check("fill_valid", memDataValid, (c == 18));
            if (c == 18) begin
                check("fill_data", memDataOut, 128'h100F0E0D0C0B0A090807060504030201);
                check("fill_memAddr", memAddr, 28'h0000120);
            end
            if (c == 19) check("fill_no_restart", ramAddr, 0);
        end

        // Write-back of line 0x00300.
        tick();
        missIn      = 1'b1;
        readWriteIn = 1'b0;
        missAddrIn  = 28'h0000300;
        writeBackIn = 128'hFFEEDDCCBBAA99887766554433221100;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 17) missIn = 1'b0;
            #1;
            if (c <= 16) begin
                check("wb_we", ramWrite, 1);
                check("wb_addr", ramAddr, 32'h3000 + c - 1);
                check("wb_data", ramDataOut, (c - 1) * 17);
            end else begin
                check("wb_we_done", ramWrite, 0);
                check("wb_memAddr", memAddr, 28'h0000300);
            end
            check("wb_ack", acceptWrite, (c == 17));
        end

        // IO word read at 0x30000.
        tick();
        mutableReq  = 1'b1;
        mutableRW   = 1'b1;
        mutableType = ACC_WORD;
        mutableAddr = 32'h0003_0000;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 6) mutableReq = 1'b0;
            #1;
            if (c <= 4) check("iord_addr", ramAddr, 32'h0003_0000 + c - 1);
            check("iord_valid", mutableMemInValid, (c == 6));
            if (c == 6) check("iord_data", mutableMemDataOut, 32'h44434241);
        end

        // clearIn blocks a half read for one cycle, then it is accepted.
        tick();
        mutableReq  = 1'b1;
        mutableRW   = 1'b1;
        mutableType = ACC_HALF;
        mutableAddr = 32'h0003_0001;
        clearIn     = 1'b1;
        tick();
        #1;
        check("clear_blocks", ramAddr, 0);
        clearIn = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) mutableReq = 1'b0;
            #1;
            if (c <= 2) check("half_addr", ramAddr, 32'h0003_0001 + c - 1);
            check("half_valid", mutableMemInValid, (c == 4));
            if (c == 4) check("half_data", mutableMemDataOut, 32'h00004342);
        end

        // Word read frozen by readyIn low in cycles 3-4; data must still be right.
        tick();
        mutableReq  = 1'b1;
        mutableType = ACC_WORD;
        mutableAddr = 32'h0003_0000;
        tick();
        tick();
        tick();
        readyIn = 1'b0;
        #1;
        check("stall_addr_hold0", ramAddr, 32'h0003_0002);
        tick();
        #1;
        check("stall_addr_hold1", ramAddr, 32'h0003_0002);
        tick();
        readyIn = 1'b1;
        seen    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!seen && mutableMemInValid) begin
                seen       = 1'b1;
                rd_word    = mutableMemDataOut;
                mutableReq = 1'b0;
            end
            tick();
        end
        mutableReq = 1'b0;
        check("stall_pulse_seen", seen, 1);
        check("stall_data", rd_word, 32'h44434241);

        // IO byte write of 0x5A with ioBufferFull high in cycles 1-2.
        tick();
        mutableReq  = 1'b1;
        mutableRW   = 1'b0;
        mutableType = ACC_BYTE;
        mutableAddr = 32'h0004_0000;
        mutableData = 32'h0000_005A;
        for (int c = 1; c <= 5; c++) begin
            tick();
            ioBufferFull = (c <= 2);
            if (c == SucCyc) mutableReq = 1'b0;
            #1;
            check("iowr_we", ramWrite, (c == WrCyc));
            if (c == WrCyc) begin
                check("iowr_addr", ramAddr, 32'h0004_0000);
                check("iowr_data", ramDataOut, 8'h5A);
            end
            check("iowr_suc", mutableWriteSuc, (c == SucCyc));
        end
        ioBufferFull = 1'b0;

        // Reset in cycle 8 of a fill.
        tick();
        missIn      = 1'b1;
        readWriteIn = 1'b1;
        missAddrIn  = 28'h0000120;
        repeat (8) tick();
        check("pre_reset_addr", ramAddr, 32'h0000_1207);
        resetIn = 1'b1;
        missIn  = 1'b0;
        #1;
        check("rst_ramAddr", ramAddr, 0);
        check("rst_ramWrite", ramWrite, 0);
        check("rst_memDataValid", memDataValid, 0);
        check("rst_memDataOut", memDataOut, 0);
        tick();
        resetIn = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (memDataValid) seen = 1'b1;
        end
        check("rst_no_fill_pulse", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
